// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback-trace capture block: one captured
// register write and the x0 index used by the filter.
package wb_trace_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_entry_t;

  localparam logic [4:0] RD_X0 = 5'd0;

endpackage

// File: rtl/wb_trace_capture_if.sv
// Bundle of the core writeback port and the host-side trace stream.
// The capture block is the slave; the core/consumer side is the master.
interface wb_trace_if;

  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;

  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [31:0] out_pc;

  modport slave (
    input  wb_we, wb_rd, wb_data, wb_pc, out_ready,
    output out_valid, out_rd, out_data, out_pc
  );

  modport master (
    output wb_we, wb_rd, wb_data, wb_pc, out_ready,
    input  out_valid, out_rd, out_data, out_pc
  );

endinterface

// File: rtl/wb_trace_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers and a registered
// head, so the output holds its last value once the FIFO drains.
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = wb_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  T            mem [DEPTH];
  T            head_q, head_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level = wptr_q - rptr_q;
  assign dout  = head_q;

  // The next head is computed from the post-edge pointers; when the slot it
  // points at is being written this same edge, the incoming entry is forwarded.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    head_d = head_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      if (wptr_d != rptr_d) begin
        if (push && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) head_d = din;
        else                                            head_d = mem[rptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
    end
  end

  // Storage carries no reset; only slots behind a valid pointer are ever read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_trace_capture.sv
// Writeback-trace reader: qualifies core register writes, buffers them in a
// FIFO and tracks captures lost to a full buffer.
module wb_trace_capture
  import wb_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit FILTER_X0 = 1'b1,
  parameter int DROP_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_trace_if.slave              bus,
  input  logic                   enable,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  logic      cap, push, pop, drop;
  logic      full, empty;
  wb_entry_t entry_in, head;

  always_comb begin
    cap  = enable & bus.wb_we & ~(FILTER_X0 & (bus.wb_rd == RD_X0));
    pop  = bus.out_valid & bus.out_ready;
    push = cap & (~full | pop);
    drop = cap & full & ~pop;
    entry_in      = '0;
    entry_in.rd   = bus.wb_rd;
    entry_in.data = bus.wb_data;
    entry_in.pc   = bus.wb_pc;
  end

  wb_trace_fifo #(
    .DEPTH (DEPTH),
    .T     (wb_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (entry_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_rd    = head.rd;
  assign bus.out_data  = head.data;
  assign bus.out_pc    = head.pc;

  // A capture in a clear cycle is lost silently, so clear outranks drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed bench for wb_trace_capture: table-driven stream checks plus
// hand-written overflow, clear, async-reset and saturation sequences.
module tb_wb_trace_capture;
  import wb_trace_pkg::*;

  logic clk = 1'b0;
  logic reset, enable, clear;

  wb_trace_if bus ();
  wb_trace_if bus2 ();

  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic [1:0]  level2;
  logic        overflow2;
  logic [1:0]  drop_count2;

  int total = 0;
  int bad   = 0;

  wb_trace_capture #(.DEPTH(16), .FILTER_X0(1'b1), .DROP_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .enable     (enable),
    .clear      (clear),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  // Small instance: exercises DEPTH=2, x0 capture and counter saturation.
  wb_trace_capture #(.DEPTH(2), .FILTER_X0(1'b0), .DROP_W(2)) dut_small (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus2),
    .enable     (enable),
    .clear      (clear),
    .level      (level2),
    .overflow   (overflow2),
    .drop_count (drop_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic        ready;
    logic        exp_valid;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [31:0] exp_pc;
    logic [4:0]  exp_level;
  } vec_t;

  vec_t vecs [14];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic we, input logic [4:0] rd,
                                input logic [31:0] data, input logic [31:0] pc, input logic ready);
    enable        = en;
    bus.wb_we     = we;
    bus.wb_rd     = rd;
    bus.wb_data   = data;
    bus.wb_pc     = pc;
    bus.out_ready = ready;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 5'd5, 32'h11,   32'h100, 1'b0, 1'b1, 5'd5, 32'h11,   32'h100, 5'd1};
    vecs[1]  = '{1'b1, 1'b1, 5'd6, 32'h22,   32'h104, 1'b0, 1'b1, 5'd5, 32'h11,   32'h100, 5'd2};
    vecs[2]  = '{1'b1, 1'b1, 5'd7, 32'h33,   32'h108, 1'b0, 1'b1, 5'd5, 32'h11,   32'h100, 5'd3};
    vecs[3]  = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,   1'b1, 1'b1, 5'd6, 32'h22,   32'h104, 5'd2};
    vecs[4]  = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,   1'b1, 1'b1, 5'd7, 32'h33,   32'h108, 5'd1};
    vecs[5]  = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,   1'b1, 1'b0, 5'd7, 32'h33,   32'h108, 5'd0};
    vecs[6]  = '{1'b1, 1'b1, 5'd0, 32'hDEAD, 32'h10C, 1'b0, 1'b0, 5'd7, 32'h33,   32'h108, 5'd0};
    vecs[7]  = '{1'b1, 1'b1, 5'd1, 32'hBEEF, 32'h110, 1'b0, 1'b1, 5'd1, 32'hBEEF, 32'h110, 5'd1};
    vecs[8]  = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,   1'b1, 1'b0, 5'd1, 32'hBEEF, 32'h110, 5'd0};
    vecs[9]  = '{1'b1, 1'b1, 5'd2, 32'h44,   32'h114, 1'b1, 1'b1, 5'd2, 32'h44,   32'h114, 5'd1};
    vecs[10] = '{1'b1, 1'b1, 5'd3, 32'h55,   32'h118, 1'b1, 1'b1, 5'd3, 32'h55,   32'h118, 5'd1};
    vecs[11] = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,   1'b0, 1'b1, 5'd3, 32'h55,   32'h118, 5'd1};
    vecs[12] = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,   1'b1, 1'b0, 5'd3, 32'h55,   32'h118, 5'd0};
    vecs[13] = '{1'b0, 1'b1, 5'd4, 32'h66,   32'h11C, 1'b0, 1'b0, 5'd3, 32'h55,   32'h118, 5'd0};

    reset = 1'b0;
    clear = 1'b0;
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    bus2.wb_we     = 1'b0;
    bus2.wb_rd     = 5'd0;
    bus2.wb_data   = 32'h0;
    bus2.wb_pc     = 32'h0;
    bus2.out_ready = 1'b0;

    #12;
    check_output("reset_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset_level", 32'(level), 32'd0);
    check_output("reset_overflow", 32'(overflow), 32'd0);
    check_output("reset_drop", 32'(drop_count), 32'd0);
    check_output("reset_rd", 32'(bus.out_rd), 32'd0);
    check_output("reset_data", bus.out_data, 32'd0);
    check_output("reset_pc", bus.out_pc, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].en, vecs[i].we, vecs[i].rd, vecs[i].data, vecs[i].pc, vecs[i].ready);
      @(negedge clk);
      check_output($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      check_output($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      check_output($sformatf("vec%0d_rd", i), 32'(bus.out_rd), 32'(vecs[i].exp_rd));
      check_output($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_data);
      check_output($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].exp_pc);
      check_output($sformatf("vec%0d_overflow", i), 32'(overflow), 32'd0);
    end

    // Overflow: 20 captures into a 16-deep FIFO with no consumer.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 1'b1, 5'((i % 31) + 1), 32'(i), 32'h2000 + 32'(4 * i), 1'b0);
      @(negedge clk);
      if (i == 15) begin
        check_output("fill16_level", 32'(level), 32'd16);
        check_output("fill16_overflow", 32'(overflow), 32'd0);
      end
    end
    apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    check_output("ovf_level", 32'(level), 32'd16);
    check_output("ovf_flag", 32'(overflow), 32'd1);
    check_output("ovf_drop", 32'(drop_count), 32'd4);
    check_output("ovf_head", bus.out_data, 32'd0);
    check_output("ovf_head_pc", bus.out_pc, 32'h2000);

    // Full FIFO with simultaneous push and pop.
    apply_stimulus(1'b1, 1'b1, 5'd9, 32'h99, 32'h3000, 1'b1);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    check_output("pushpop_level", 32'(level), 32'd16);
    check_output("pushpop_drop", 32'(drop_count), 32'd4);
    check_output("pushpop_head", bus.out_data, 32'd1);

    for (int k = 0; k < 16; k++) begin
      check_output($sformatf("drain%0d_valid", k), 32'(bus.out_valid), 32'd1);
      check_output($sformatf("drain%0d_data", k), bus.out_data, (k < 15) ? 32'(k + 1) : 32'h99);
      apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
    end
    apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    check_output("drain_level", 32'(level), 32'd0);
    check_output("drain_valid", 32'(bus.out_valid), 32'd0);

    // Clear outranks a capture in the same cycle.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b1, 5'd8, 32'h70 + 32'(i), 32'h4000, 1'b0);
      @(negedge clk);
    end
    check_output("preclear_level", 32'(level), 32'd3);
    clear = 1'b1;
    apply_stimulus(1'b1, 1'b1, 5'd9, 32'h77, 32'h4010, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    check_output("clear_level", 32'(level), 32'd0);
    check_output("clear_overflow", 32'(overflow), 32'd0);
    check_output("clear_drop", 32'(drop_count), 32'd0);
    check_output("clear_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check_output("clear_lost", 32'(level), 32'd0);

    // Async reset pulse between clock edges.
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 1'b1, 5'd10, 32'hA0 + 32'(i), 32'h5000, 1'b0);
      @(negedge clk);
    end
    apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    check_output("prerst_level", 32'(level), 32'd2);
    @(posedge clk);
    #1 reset = 1'b0;
    #2;
    check_output("async_valid", 32'(bus.out_valid), 32'd0);
    check_output("async_level", 32'(level), 32'd0);
    check_output("async_data", bus.out_data, 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    check_output("postrst_level", 32'(level), 32'd0);

    // Small instance: x0 accepted, drop counter saturates at 3.
    for (int i = 0; i < 6; i++) begin
      bus2.wb_we   = 1'b1;
      bus2.wb_rd   = 5'd0;
      bus2.wb_data = 32'h50 + 32'(i);
      bus2.wb_pc   = 32'h6000 + 32'(4 * i);
      @(negedge clk);
      if (i == 3) check_output("small_drop2", 32'(drop_count2), 32'd2);
    end
    bus2.wb_we = 1'b0;
    check_output("small_level", 32'(level2), 32'd2);
    check_output("small_overflow", 32'(overflow2), 32'd1);
    check_output("small_drop_sat", 32'(drop_count2), 32'd3);
    check_output("small_valid", 32'(bus2.out_valid), 32'd1);
    check_output("small_rd", 32'(bus2.out_rd), 32'd0);
    check_output("small_data", bus2.out_data, 32'h50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
